// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Queue entries pair a fetched instruction word with the PC it was read from.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries with synchronous flush.
// Head is read straight from storage; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Stale entries stay in storage; only the pointers and count matter.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues 1-cycle-latency imem reads and queues results for decode.
// Credit rule (queued + in flight < DEPTH) means a returning word always has a free slot.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr,
  output logic [XLEN-1:0]   instr_pc,
  output logic [XLEN-1:0]   instr_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic [OW-1:0]   occupancy;
  logic            issue;
  logic            push;
  logic            pop;

  // An outstanding read already owns a slot, so it counts against the credit.
  assign occupancy = {1'b0, count} + OW'(inflight);
  assign issue     = rst && fetch_en && !redirect_valid && (occupancy < DEPTH_W);
  assign push      = inflight && !redirect_valid && !full;
  assign pop       = instr_valid && instr_ready;
  assign push_data = '{instr: imem_rdata, pc: inflight_pc};

  assign imem_req       = issue;
  assign imem_addr      = fetch_pc[ADDR_W-1:0];
  assign instr_valid    = !empty;
  assign instr          = head.instr;
  assign instr_pc       = head.pc;
  assign instr_pc_plus4 = head.pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked every
// cycle against a queue-of-issued-PCs reference model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 12;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_en = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic [31:0]       instr_pc_plus4;

  fetch_queue #(.XLEN(32), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory returns its own address one cycle after a request; garbage otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? 32'(imem_addr) : $urandom;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] mfpc = RESET_PC;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          nreq = 0;
  int          seen_wrap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic er, ev;
    @(negedge clk);
    if (!rst) begin
      pend.delete();
      mfpc = RESET_PC;
    end
    er = rst && fetch_en && !redirect_valid && (pend.size() < DEPTH);
    ev = rst && (pend.size() > 0) && (pend[0].cyc <= cyc - 2);
    check("imem_req", 32'(imem_req), 32'(er));
    check("imem_addr", 32'(imem_addr), 32'(mfpc[ADDR_W-1:0]));
    check("instr_valid", 32'(instr_valid), 32'(ev));
    if (imem_req) check("no_push_when_full", 32'(pend.size() < DEPTH), 32'd1);
    if (ev) begin
      check("instr_pc", instr_pc, pend[0].pc);
      check("instr", instr, 32'(pend[0].pc[ADDR_W-1:0]));
      check("instr_pc_plus4", instr_pc_plus4, pend[0].pc + 32'd4);
    end
    if (!rst) begin
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_pc_plus4", instr_pc_plus4, 32'h4);
    end
    if (imem_req) nreq++;
    if (ev && instr_ready && !redirect_valid && instr_pc == 32'h1000) seen_wrap++;
    if (rst) begin
      if (redirect_valid) begin
        pend.delete();
        mfpc = redirect_pc & ~32'h3;
      end else begin
        if (ev && instr_ready) void'(pend.pop_front());
        if (er) begin
          pend.push_back('{pc: mfpc, cyc: cyc});
          mfpc = mfpc + 32'd4;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state and back-to-back stream from RESET_PC.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (10) step();

    // Stall decode: exactly DEPTH requests, head held.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    nreq = 0;
    repeat (10) step();
    check("stall_req_pulses", 32'(nreq), 32'(DEPTH));
    check("stall_head_pc", instr_pc, RESET_PC);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) step();

    // Redirect with one read in flight and queued entries.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) step();
    drive(1'b1, 1'b0, 1'b1, 32'h100);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("redirect_addr", 32'(imem_addr), 32'h100);
    repeat (6) step();

    // Misaligned redirect concurrent with a pop.
    drive(1'b1, 1'b1, 1'b1, 32'h102);
    check("pop_during_redirect_valid", 32'(instr_valid), 32'd1);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) step();

    // Address wrap at the top of imem.
    seen_wrap = 0;
    drive(1'b1, 1'b1, 1'b1, 32'hFFC);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) step();
    check("wrap_pc_seen", 32'(seen_wrap), 32'd1);

    // Asynchronous reset while the queue is full.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (8) step();
    check("full_before_reset", 32'(instr_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_req", 32'(imem_req), 32'd0);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rpc;
      case ($urandom_range(3))
        0:       rpc = 32'hFFC;
        1:       rpc = 32'hFFFF_FFF8;
        2:       rpc = $urandom & 32'h1FFF;
        default: rpc = $urandom;
      endcase
      drive(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0, rpc);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
